// File: rtl/iram_loader_if.sv
// iram_loader_if
// Groups the byte-stream handshake and the iram write port of the boot loader.
//   in_data/in_valid/in_ready : byte stream, a byte moves when valid && ready
//   mem_address               : iram word address
//   mem_write_data            : iram write data
//   mem_read_not_write        : 0 only during a loader write cycle
//   mem_cs                    : iram chip select
// Modport master is the loader side; modport slave is the stream source / iram side.
interface iram_loader_if #(
    parameter int unsigned ADDRESS_BUS_WIDTH = 11,
    parameter int unsigned INSTRUCTION_WIDTH = 24
);
    logic [7:0]                   in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [ADDRESS_BUS_WIDTH-1:0] mem_address;
    logic [INSTRUCTION_WIDTH-1:0] mem_write_data;
    logic                         mem_read_not_write;
    logic                         mem_cs;

    modport master (
        input  in_data, in_valid,
        output in_ready, mem_address, mem_write_data, mem_read_not_write, mem_cs
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_address, mem_write_data, mem_read_not_write, mem_cs
    );
endinterface

// File: rtl/iram_loader.sv
// iram_loader
// Boot-time program loader and write side of the instruction RAM. Receives a
// byte stream (16-bit word count N, N x 3-byte words MSB first, checksum byte),
// writes each assembled 24-bit word to iram and holds the CPU until a complete
// image with an 8-bit byte sum of zero has been loaded.
//   clock, reset     : system clock, asynchronous active-high reset
//   start            : one-cycle load request (honoured in IDLE, DONE, ERROR)
//   bus              : stream handshake and iram write port (master side)
//   cpu_hold         : high in every state except DONE
//   busy/done/error  : load in progress / last load succeeded / last load failed
//   words_loaded     : words written in the current or last load
module iram_loader #(
    parameter int unsigned                  ADDRESS_BUS_WIDTH = 11,
    parameter int unsigned                  INSTRUCTION_WIDTH = 24,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] BASE_ADDR         = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    iram_loader_if.master              bus,
    output logic                       cpu_hold,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [ADDRESS_BUS_WIDTH:0] words_loaded
);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDRESS_BUS_WIDTH;

    typedef enum logic [3:0] {
        IDLE, HDR_HI, HDR_LO, B0, B1, B2, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t                       state_q;
    logic [7:0]                   hdr_hi_q;
    logic [15:0]                  count_q;
    logic [7:0]                   sum_q;
    logic [7:0]                   b0_q;
    logic [7:0]                   b1_q;
    logic [ADDRESS_BUS_WIDTH-1:0] mem_address_q;
    logic [INSTRUCTION_WIDTH-1:0] mem_write_data_q;
    logic                         mem_rnw_q;
    logic                         mem_cs_q;
    logic                         cpu_hold_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         error_q;
    logic [ADDRESS_BUS_WIDTH:0]   words_loaded_q;

    logic        in_ready;
    logic        xfer;
    logic [16:0] hdr_count;

    // in_ready is the only output decoded combinationally from the state.
    always_comb begin
        in_ready = state_q inside {HDR_HI, HDR_LO, B0, B1, B2, CHECK};
    end

    assign xfer      = bus.in_valid && in_ready;
    assign hdr_count = {1'b0, hdr_hi_q, bus.in_data};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            hdr_hi_q         <= '0;
            count_q          <= '0;
            sum_q            <= '0;
            b0_q             <= '0;
            b1_q             <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_rnw_q        <= 1'b1;
            mem_cs_q         <= 1'b0;
            cpu_hold_q       <= 1'b1;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            words_loaded_q   <= '0;
        end else begin
            // The write strobe is a one-cycle pulse armed by the third byte.
            mem_cs_q  <= 1'b0;
            mem_rnw_q <= 1'b1;
            if (xfer) begin
                sum_q <= sum_q + bus.in_data;
            end
            unique case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q        <= HDR_HI;
                        sum_q          <= '0;
                        words_loaded_q <= '0;
                        done_q         <= 1'b0;
                        error_q        <= 1'b0;
                        busy_q         <= 1'b1;
                        cpu_hold_q     <= 1'b1;
                    end
                end
                HDR_HI: begin
                    if (xfer) begin
                        hdr_hi_q <= bus.in_data;
                        state_q  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        if (hdr_count != '0 && hdr_count <= MAX_WORDS) begin
                            count_q <= hdr_count[15:0];
                            state_q <= B0;
                        end else begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                B0: begin
                    if (xfer) begin
                        b0_q    <= bus.in_data;
                        state_q <= B1;
                    end
                end
                B1: begin
                    if (xfer) begin
                        b1_q    <= bus.in_data;
                        state_q <= B2;
                    end
                end
                B2: begin
                    // Address/data are loaded here so they are valid for the
                    // whole WRITE cycle and hold afterwards.
                    if (xfer) begin
                        mem_write_data_q <= {b0_q, b1_q, bus.in_data};
                        mem_address_q    <= BASE_ADDR + words_loaded_q[ADDRESS_BUS_WIDTH-1:0];
                        mem_cs_q         <= 1'b1;
                        mem_rnw_q        <= 1'b0;
                        state_q          <= WRITE;
                    end
                end
                WRITE: begin
                    words_loaded_q <= words_loaded_q + 1'b1;
                    if ((17'(words_loaded_q) + 17'd1) < {1'b0, count_q}) begin
                        state_q <= B0;
                    end else begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        busy_q <= 1'b0;
                        if (8'(sum_q + bus.in_data) == 8'd0) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready           = in_ready;
    assign bus.mem_address        = mem_address_q;
    assign bus.mem_write_data     = mem_write_data_q;
    assign bus.mem_read_not_write = mem_rnw_q;
    assign bus.mem_cs             = mem_cs_q;
    assign cpu_hold               = cpu_hold_q;
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign error                  = error_q;
    assign words_loaded           = words_loaded_q;
endmodule
